// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the IF stage (read-only)
// and the DM stage (read/write). One command is in flight at a time. Each access ends
// with a one-cycle ready pulse to its owner, and the read data is held in a per-stage register.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; the next edge with a request grants a winner
// ISSUE  | one-cycle command strobe to memory
// WAIT   | waiting for mem_rsp_valid; timeout timer counts down
// DONE   | owner's ready pulse; no arbitration in this cycle
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_cmd_valid,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner,
    output logic              timeout_err
);

    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);
    localparam logic [TW-1:0] TMR_LOAD   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] streak;
    logic [TW-1:0] tmr;
    logic          grant_dm;
    logic          tmr_tc;

    // DM wins a contested grant unless IF has already been passed over STREAK_MAX times in a row
    assign grant_dm = dm_req & (~if_req | (streak != STREAK_TOP));
    assign tmr_tc   = (tmr == '0);

    // Stalls follow the live request so the pipeline releases in the ready cycle itself
    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the per-state strobes
    always_comb begin
        state_nxt     = state;
        mem_cmd_valid = 1'b0;
        if_ready      = 1'b0;
        dm_ready      = 1'b0;
        busy          = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (if_req | dm_req) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_cmd_valid = 1'b1;
                state_nxt     = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid | tmr_tc) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if_ready  = ~owner;
                dm_ready  = owner;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant capture, fairness streak, timeout timer and read-data registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner       <= 1'b0;
            mem_cmd_we  <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            streak      <= '0;
            tmr         <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_req | dm_req) begin
                        owner <= grant_dm;
                        if (grant_dm) begin
                            mem_cmd_we <= dm_we;
                            mem_addr   <= dm_addr;
                            mem_wdata  <= dm_wdata;
                            if (if_req) begin
                                streak <= (streak == STREAK_TOP) ? streak : streak + 1'b1;
                            end else begin
                                streak <= '0;
                            end
                        end else begin
                            mem_cmd_we <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                            streak     <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    tmr <= TMR_LOAD;
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (!owner) begin
                            if_rdata <= mem_rdata;
                        end else if (!mem_cmd_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end else if (tmr_tc) begin
                        timeout_err <= 1'b1;
                        if (!owner) begin
                            if_rdata <= '0;
                        end else begin
                            dm_rdata <= '0;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
